// File: rtl/mux_pkg.sv
// mux_pkg: shared mode/state constants and channel slicing helper for mux_bus_scan
package mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  typedef logic [0:0] state_t;
  localparam state_t ST_MANUAL = 1'b0;
  localparam state_t ST_SCAN = 1'b1;
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr: round-robin channel pointer with per-channel dwell counter and wrap pulse
module mux_scan_ctr #(
  parameter int CHANNELS = 8,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(CHANNELS),
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SEL_W-1:0] start,
  input  logic             en,
  output logic [SEL_W-1:0] ptr,
  output logic             wrap
);
  logic [DW_W-1:0] dwell;
  logic last, top;
  assign last = dwell == DW_W'(DWELL - 1);
  assign top = ptr == SEL_W'(CHANNELS - 1);
  // load on scan entry, otherwise count dwell and step the pointer when it expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      dwell <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      ptr <= start;
      dwell <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= en && last && top;
      if (en) begin
        dwell <= last ? '0 : dwell + 1'b1;
        ptr <= last ? (top ? '0 : ptr + 1'b1) : ptr;
      end
    end
  end
endmodule

// File: rtl/mux_bus_scan.sv
// mux_bus_scan: registered N-channel bus mux with manual select and auto-scan mode
module mux_bus_scan import mux_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 8,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      wrap
);
  state_t st;
  logic in_range, scan_now, load, en, valid_n;
  logic [SEL_W-1:0] ptr, src, start;
  logic [WIDTH-1:0] data;
  // scanning only continues while mode stays high; a drop takes effect on the same edge
  always_comb begin
    in_range = int'(sel) < CHANNELS;
    scan_now = st == ST_SCAN && mode == MODE_SCAN;
    load = st == ST_MANUAL && mode == MODE_SCAN;
    en = scan_now && !hold;
    start = in_range ? sel : '0;
    src = scan_now ? ptr : sel;
    data = in_bus[slice_lo(int'(src), WIDTH) +: WIDTH];
    valid_n = scan_now || in_range;
  end
  mux_scan_ctr #(.CHANNELS(CHANNELS), .DWELL(DWELL)) u_ctr (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .start(start),
    .en(en),
    .ptr(ptr),
    .wrap(wrap)
  );
  // mode state plus the registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_MANUAL;
      out <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
    end else begin
      st <= (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      out <= valid_n ? data : '0;
      out_ch <= src;
      out_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_mux_bus_scan.sv
// tb_mux_bus_scan: three DUT configurations checked against a scan-time model plus directed literals
module tb_mux_bus_scan;
  localparam int CC[3] = '{8, 8, 6};
  localparam int DD[3] = '{2, 4, 4};
  logic clk, rst_n, mode, hold;
  logic [2:0] sel;
  logic [3:0] dat[8];
  logic [31:0] bus8;
  logic [23:0] bus6;
  logic [3:0] o[3];
  logic [2:0] oc[3];
  logic ov[3], ow[3];
  logic [7:0] eo[3], ec[3], ev[3], ew[3];
  bit scan[3];
  int start[3], t[3];
  int mc, nc;
  int checks = 0, errors = 0;

  always_comb for (int k = 0; k < 8; k++) bus8[k*4 +: 4] = dat[k];
  assign bus6 = bus8[23:0];

  mux_bus_scan #(.WIDTH(4), .CHANNELS(8), .DWELL(2)) u0 (.clk(clk), .rst_n(rst_n), .in_bus(bus8), .sel(sel),
    .mode(mode), .hold(hold), .out(o[0]), .out_ch(oc[0]), .out_valid(ov[0]), .wrap(ow[0]));
  mux_bus_scan #(.WIDTH(4), .CHANNELS(8), .DWELL(4)) u1 (.clk(clk), .rst_n(rst_n), .in_bus(bus8), .sel(sel),
    .mode(mode), .hold(hold), .out(o[1]), .out_ch(oc[1]), .out_valid(ov[1]), .wrap(ow[1]));
  mux_bus_scan #(.WIDTH(4), .CHANNELS(6), .DWELL(4)) u2 (.clk(clk), .rst_n(rst_n), .in_bus(bus6), .sel(sel),
    .mode(mode), .hold(hold), .out(o[2]), .out_ch(oc[2]), .out_valid(ov[2]), .wrap(ow[2]));

  initial clk = 0;
  always #5 clk = ~clk;

  // model: channel shown = (start + unheld scan cycles / DWELL) mod CHANNELS
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        scan[i] = 0; start[i] = 0; t[i] = 0;
        eo[i] = 0; ec[i] = 0; ev[i] = 0; ew[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (scan[i] && mode) begin
          mc = (start[i] + t[i] / DD[i]) % CC[i];
          eo[i] = 8'(dat[mc]); ec[i] = 8'(mc); ev[i] = 1; ew[i] = 0;
          if (!hold) begin
            t[i]++;
            nc = (start[i] + t[i] / DD[i]) % CC[i];
            ew[i] = 8'((mc == CC[i] - 1) && (nc == 0));
          end
        end else begin
          ev[i] = 8'(int'(sel) < CC[i]);
          eo[i] = ev[i] != 0 ? 8'(dat[sel]) : 8'd0;
          ec[i] = 8'(sel); ew[i] = 0;
          if (mode && !scan[i]) begin
            start[i] = int'(sel) < CC[i] ? int'(sel) : 0;
            t[i] = 0;
          end
          scan[i] = mode;
        end
      end
    end
  end

  task automatic chk(input string n, input logic [7:0] g, input logic [7:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", n, g, e);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d out", i), 8'(o[i]), eo[i]);
      chk($sformatf("u%0d out_ch", i), 8'(oc[i]), ec[i]);
      chk($sformatf("u%0d out_valid", i), 8'(ov[i]), ev[i]);
      chk($sformatf("u%0d wrap", i), 8'(ow[i]), ew[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    compare_all();
  endtask

  initial begin
    int sv[5] = '{3, 5, 7, 0, 2};
    int mo[5] = '{3, 2, 14, 12, 1};
    int sq[8] = '{11, 11, 14, 14, 12, 12, 15, 15};
    int wq[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int rq[4] = '{9, 9, 9, 3};
    int ini[8] = '{12, 15, 1, 3, 5, 2, 11, 14};
    for (int k = 0; k < 8; k++) dat[k] = 4'(ini[k]);
    rst_n = 0; mode = 0; sel = 0; hold = 0;
    #1;
    compare_all();
    chk("reset out", 8'(o[1]), 0);
    chk("reset valid", 8'(ov[1]), 0);
    repeat (2) tick();
    rst_n = 1;
    #1;
    compare_all();
    chk("post-release out", 8'(o[1]), 0);
    chk("post-release valid", 8'(ov[1]), 0);
    for (int k = 0; k < 5; k++) begin
      sel = 3'(sv[k]);
      tick();
      chk("manual out", 8'(o[1]), 8'(mo[k]));
      chk("manual out_ch", 8'(oc[1]), 8'(sv[k]));
      chk("manual valid", 8'(ov[1]), 1);
    end
    sel = 6; mode = 1;
    tick();
    chk("scan entry out", 8'(o[0]), 11);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("scan out", 8'(o[0]), 8'(sq[k]));
      chk("scan wrap", 8'(ow[0]), 8'(wq[k]));
    end
    mode = 0; sel = 2;
    tick();
    chk("manual return", 8'(o[1]), 1);
    mode = 1;
    tick();
    tick();
    chk("hold pre", 8'(o[1]), 1);
    hold = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) dat[2] = 9;
      tick();
      chk("hold out", 8'(o[1]), k >= 3 ? 8'd9 : 8'd1);
      chk("hold wrap", 8'(ow[1]), 0);
    end
    hold = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("release out", 8'(o[1]), 8'(rq[k]));
    end
    dat[2] = 1;
    mode = 0; sel = 6;
    tick();
    chk("oor6 out", 8'(o[2]), 0);
    chk("oor6 valid", 8'(ov[2]), 0);
    chk("oor6 out_ch", 8'(oc[2]), 6);
    sel = 7;
    tick();
    chk("oor7 valid", 8'(ov[2]), 0);
    chk("oor7 out_ch", 8'(oc[2]), 7);
    mode = 1;
    tick();
    chk("oor entry valid", 8'(ov[2]), 0);
    tick();
    chk("oor scan out", 8'(o[2]), 12);
    chk("oor scan ch", 8'(oc[2]), 0);
    chk("oor scan valid", 8'(ov[2]), 1);
    mode = 0;
    tick();
    sel = 5; mode = 1;
    tick();
    tick();
    chk("ch5 out", 8'(o[1]), 2);
    chk("ch5 out_ch", 8'(oc[1]), 5);
    #1 rst_n = 0;
    #1;
    compare_all();
    chk("async rst out", 8'(o[1]), 0);
    chk("async rst ch", 8'(oc[1]), 0);
    chk("async rst valid", 8'(ov[1]), 0);
    sel = 1;
    #2 rst_n = 1;
    tick();
    chk("rerun entry out", 8'(o[1]), 15);
    chk("rerun entry valid", 8'(ov[1]), 1);
    tick();
    chk("rerun scan out", 8'(o[1]), 15);
    chk("rerun scan ch", 8'(oc[1]), 1);
    repeat (12) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
